// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and helpers for the MEM-stage data memory.
// The DMEM_PARITY_EN build adds per-byte even parity in data_mem_unit.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic m;
        m = 1'b1;
        unique case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = off[0];
            SZ_WORD: m = |off;
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_par(input logic [31:0] w);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and replicated wdata,
// plus load byte/half extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  lanes_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword_i[{off_i, 3'b000} +: 8];
    assign rhalf = off_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        lanes_o = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = 32'h0;
        unique case (size_i)
            SZ_BYTE: begin
                lanes_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                lanes_o = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{signed_i & rhalf[15]}}, rhalf};
            end
            SZ_WORD: begin
                lanes_o = 4'b1111;
                rdata_o = rword_i;
            end
            default: begin
                lanes_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressed MEM-stage data memory with wait states and valid/ready request.
// Define DMEM_PARITY_EN to add one even-parity bit per byte and par_err.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 8,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = "memory_init.mem"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        par_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    logic [31:0] mem [DEPTH];

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic                  sgn_q;
    logic [1:0]            size_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic        err_d;
    logic        par_d;
    logic [31:0] rword;
    logic [3:0]  lanes;
    logic [31:0] wsh;
    logic [31:0] ld_data;
    logic        commit;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
    assign rword  = mem[idx_q];
    assign err_d  = is_misaligned(size_q, off_q);
    assign commit = (state_q == RESP) && we_q && !err_d;

    dmem_lane_align u_align (
        .size_i   (size_q),
        .signed_i (sgn_q),
        .off_i    (off_q),
        .wdata_i  (wdata_q),
        .rword_i  (rword),
        .lanes_o  (lanes),
        .wdata_o  (wsh),
        .rdata_o  (ld_data)
    );

`ifdef DMEM_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic       par_q;

    assign par_d   = !we_q && !err_d &&
                     |(lanes & (par_mem[idx_q] ^ byte_par(rword)));
    assign par_err = par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (state_q == RESP) begin
            par_q <= par_d;
        end
    end
`else
    assign par_d   = 1'b0;
    assign par_err = par_d;
`endif

    // Array has no reset: an aborted access never reaches RESP, so it never commits.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    mem[idx_q][8*i +: 8] <= wsh[8*i +: 8];
`ifdef DMEM_PARITY_EN
                    par_mem[idx_q][i] <= ^wsh[8*i +: 8];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        sgn_q   <= req_signed;
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        idx_q   <= req_addr[ADDR_WIDTH+1:2];
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        cnt_q   <= WS_INIT;
                        state_q <= (WAIT_STATES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    err_q       <= err_d;
                    rdata_q     <= (we_q || err_d) ? 32'h0 : ld_data;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit with WAIT_STATES=3, no preload.
module tb_data_mem_unit;

    localparam int WS  = 3;
    localparam int LAT = WS + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        par_err;

    typedef struct {
        string       name;
        bit          chk;
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_acc = 0;

    data_mem_unit #(
        .ADDR_WIDTH  (8),
        .WAIT_STATES (WS),
        .INIT_FILE   ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 at cyc %0d",
                             cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
                    if (e.chk) check({e.name, "_rdata"}, rsp_rdata, e.data);
                    check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(LAT));
                    check({e.name, "_par"}, 32'(par_err), 32'd0);
                end
            end
        end
    end

    task automatic issue(input string nm, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [31:0] ed,
                         input logic ee, input bit want);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_ready_timeout: got req_ready=0 expected 1", nm);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (want) begin
            e.name = nm;
            e.chk  = !we;
            e.data = ed;
            e.err  = ee;
            e.acc  = cyc;
            exp_q.push_back(e);
        end
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: got %0d pending expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int acc1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_par", 32'(par_err), 32'd0);
        rst_n = 1'b1;

        issue("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 1);
        issue("lw10", 0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1);
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("busy_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        check("done_ready", 32'(req_ready), 32'd1);

        issue("tp_a", 0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 1);
        acc1 = last_acc;
        issue("tp_b", 0, 2'b10, 1, 32'h10, 0, 32'hDEADBEEF, 0, 1);
        check("throughput", 32'(last_acc - acc1), 32'(WS + 2));

        issue("sw20", 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 0, 0, 1);
        issue("lb23", 0, 2'b00, 1, 32'h23, 0, 32'hFFFFFF80, 0, 1);
        issue("lbu23", 0, 2'b00, 0, 32'h23, 0, 32'h00000080, 0, 1);
        issue("lb20", 0, 2'b00, 1, 32'h20, 0, 32'h00000001, 0, 1);
        issue("lh20", 0, 2'b01, 1, 32'h20, 0, 32'h00007F01, 0, 1);
        issue("lh22", 0, 2'b01, 1, 32'h22, 0, 32'hFFFF80FF, 0, 1);
        issue("lhu22", 0, 2'b01, 0, 32'h22, 0, 32'h000080FF, 0, 1);
        issue("sb21", 1, 2'b00, 0, 32'h21, 32'h123456AA, 0, 0, 1);
        issue("lw20a", 0, 2'b10, 0, 32'h20, 0, 32'h80FFAA01, 0, 1);

        issue("lw22", 0, 2'b10, 0, 32'h22, 0, 32'h0, 1, 1);
        issue("sh21", 1, 2'b01, 0, 32'h21, 32'h5555, 0, 1, 1);
        issue("rsvd", 0, 2'b11, 0, 32'h20, 0, 32'h0, 1, 1);
        issue("lw20b", 0, 2'b10, 0, 32'h20, 0, 32'h80FFAA01, 0, 1);

        issue("sh12", 1, 2'b01, 0, 32'h12, 32'hCAFEBEEF, 0, 0, 1);
        issue("lw10b", 0, 2'b10, 0, 32'h10, 0, 32'hBEEFBEEF, 0, 1);

        issue("sw400", 1, 2'b10, 0, 32'h400, 32'h12345678, 0, 0, 1);
        issue("lw000", 0, 2'b10, 0, 32'h000, 0, 32'h12345678, 0, 1);

        issue("sw40", 1, 2'b10, 0, 32'h40, 32'h11112222, 0, 0, 1);
        drain("pre_rst");
        issue("abort", 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rdata", rsp_rdata, 32'h0);
        repeat (6) begin
            @(negedge clk);
            check("abort_novalid", 32'(rsp_valid), 32'd0);
        end
        issue("lw40", 0, 2'b10, 0, 32'h40, 0, 32'h11112222, 0, 1);

        drain("end");
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
